// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   port_id_t  : identifies a requester (PORT_CPU / PORT_DMA)
//   rd_owner_t : which port owns the read data returning next cycle
package dmem_arb_pkg;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// Ports:
//   iclk, irst        : clock, asynchronous active-high reset
//   ireq0, ireq1      : requests
//   ogrant0, ogrant1  : combinational grants in the request cycle
// The pointer names the preferred port under contention and moves to the
// other port after every grant.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic iclk,
  input  logic irst,
  input  logic ireq0,
  input  logic ireq1,
  output logic ogrant0,
  output logic ogrant1
);

  port_id_t ptr_q, ptr_d;

  always_comb begin
    ogrant0 = 1'b0;
    ogrant1 = 1'b0;
    if (ireq0 && ireq1) begin
      ogrant0 = (ptr_q == PORT_CPU);
      ogrant1 = (ptr_q == PORT_DMA);
    end else begin
      ogrant0 = ireq0;
      ogrant1 = ireq1;
    end

    ptr_d = ptr_q;
    if (ogrant0) begin
      ptr_d = PORT_DMA;
    end else if (ogrant1) begin
      ptr_d = PORT_CPU;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      ptr_q <= PORT_CPU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port synchronous-read data memory between the CPU
// MEM stage (port 0) and the debug/loader DMA (port 1).
// Ports:
//   iclk, irst                          : clock, async active-high reset
//   ireqX/iweX/iaddrX/iwdataX/ibeX      : request, write, byte addr, data, byte enables
//   ograntX                             : access accepted this cycle (combinational)
//   ostall0                             : ireq0 & ~ogrant0
//   ordataX/orvalidX                    : read return, one cycle after grant
//   omem_en/we/addr/wdata/be, imem_rdata: memory interface
// Optional (macro DMEM_ARB_STATS_EN): ostat_conflicts, ostat_stall0
// saturating counters of contention cycles and CPU stall cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  ireq0,
  input  logic                  iwe0,
  input  logic [ADDR_WIDTH-1:0] iaddr0,
  input  logic [DATA_WIDTH-1:0] iwdata0,
  input  logic [BE_WIDTH-1:0]   ibe0,
  output logic                  ogrant0,
  output logic                  ostall0,
  output logic [DATA_WIDTH-1:0] ordata0,
  output logic                  orvalid0,
  input  logic                  ireq1,
  input  logic                  iwe1,
  input  logic [ADDR_WIDTH-1:0] iaddr1,
  input  logic [DATA_WIDTH-1:0] iwdata1,
  input  logic [BE_WIDTH-1:0]   ibe1,
  output logic                  ogrant1,
  output logic [DATA_WIDTH-1:0] ordata1,
  output logic                  orvalid1,
  output logic                  omem_en,
  output logic                  omem_we,
  output logic [ADDR_WIDTH-1:0] omem_addr,
  output logic [DATA_WIDTH-1:0] omem_wdata,
  output logic [BE_WIDTH-1:0]   omem_be,
  input  logic [DATA_WIDTH-1:0] imem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]           ostat_conflicts,
  output logic [31:0]           ostat_stall0
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BE_WIDTH - 1);

  rd_owner_t             rd_owner_q, rd_owner_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  rr_arbiter2 u_rr (
    .iclk    (iclk),
    .irst    (irst),
    .ireq0   (ireq0),
    .ireq1   (ireq1),
    .ogrant0 (ogrant0),
    .ogrant1 (ogrant1)
  );

  assign ostall0 = ireq0 & ~ogrant0;

  always_comb begin
    omem_en    = 1'b0;
    omem_we    = 1'b0;
    omem_addr  = '0;
    omem_wdata = '0;
    omem_be    = '0;
    rd_owner_d = NONE;
    if (ogrant0) begin
      omem_en    = 1'b1;
      omem_we    = iwe0;
      omem_addr  = iaddr0 & ALIGN_MASK;
      omem_wdata = iwdata0;
      omem_be    = iwe0 ? ibe0 : '1;
      rd_owner_d = iwe0 ? NONE : CPU;
    end else if (ogrant1) begin
      omem_en    = 1'b1;
      omem_we    = iwe1;
      omem_addr  = iaddr1 & ALIGN_MASK;
      omem_wdata = iwdata1;
      omem_be    = iwe1 ? ibe1 : '1;
      rd_owner_d = iwe1 ? NONE : DMA;
    end
  end

  // Memory data arrives in the cycle after the grant, so the return path
  // passes imem_rdata straight through while valid and holds it afterwards.
  always_comb begin
    orvalid0 = (rd_owner_q == CPU);
    orvalid1 = (rd_owner_q == DMA);
    rdata0_d = orvalid0 ? imem_rdata : rdata0_q;
    rdata1_d = orvalid1 ? imem_rdata : rdata1_q;
    ordata0  = rdata0_d;
    ordata1  = rdata1_d;
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      rd_owner_q <= NONE;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] conflicts_q, conflicts_d;
  logic [31:0] stall0_q, stall0_d;

  always_comb begin
    conflicts_d = conflicts_q;
    stall0_d    = stall0_q;
    if (ireq0 && ireq1 && (conflicts_q != '1)) begin
      conflicts_d = conflicts_q + 32'd1;
    end
    if (ostall0 && (stall0_q != '1)) begin
      stall0_d = stall0_q + 32'd1;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      conflicts_q <= '0;
      stall0_q    <= '0;
    end else begin
      conflicts_q <= conflicts_d;
      stall0_q    <= stall0_d;
    end
  end

  assign ostat_conflicts = conflicts_q;
  assign ostat_stall0    = stall0_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        irst;
  logic        ireq0, iwe0, ireq1, iwe1;
  logic [31:0] iaddr0, iwdata0, iaddr1, iwdata1;
  logic [3:0]  ibe0, ibe1;
  logic        ogrant0, ostall0, orvalid0, ogrant1, orvalid1;
  logic [31:0] ordata0, ordata1;
  logic        omem_en, omem_we;
  logic [31:0] omem_addr, omem_wdata;
  logic [3:0]  omem_be;
  logic [31:0] imem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] ostat_conflicts, ostat_stall0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .iclk(clk), .irst(irst),
    .ireq0(ireq0), .iwe0(iwe0), .iaddr0(iaddr0), .iwdata0(iwdata0), .ibe0(ibe0),
    .ogrant0(ogrant0), .ostall0(ostall0), .ordata0(ordata0), .orvalid0(orvalid0),
    .ireq1(ireq1), .iwe1(iwe1), .iaddr1(iaddr1), .iwdata1(iwdata1), .ibe1(ibe1),
    .ogrant1(ogrant1), .ordata1(ordata1), .orvalid1(orvalid1),
    .omem_en(omem_en), .omem_we(omem_we), .omem_addr(omem_addr),
    .omem_wdata(omem_wdata), .omem_be(omem_be), .imem_rdata(imem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .ostat_conflicts(ostat_conflicts), .ostat_stall0(ostat_stall0)
`endif
  );

  // Environment: synchronous-read data memory driven by the DUT (64 words).
  logic [31:0] tb_mem [64];
  always_ff @(posedge clk) begin
    if (omem_en) begin
      if (omem_we) begin
        for (int b = 0; b < 4; b++)
          if (omem_be[b]) tb_mem[omem_addr[7:2]][8*b +: 8] <= omem_wdata[8*b +: 8];
      end else begin
        imem_rdata <= tb_mem[omem_addr[7:2]];
      end
    end
  end

  // Reference model: word array plus arbitration rules.
  logic [31:0] ref_mem [64];
  int          m_ptr;       // preferred port under contention
  int          m_pend;      // 0 none, 1 cpu, 2 dma: read data due next cycle
  logic [31:0] m_pend_data, m_last0, m_last1;
  int          m_conf, m_stall;
  logic        exp_g0, exp_g1, exp_stall0, exp_rv0, exp_rv1, exp_en, exp_we;
  logic [31:0] exp_rd0, exp_rd1, exp_addr;
  logic [3:0]  exp_be;

  task automatic model_reset();
    m_ptr = 0; m_pend = 0; m_last0 = 0; m_last1 = 0; m_conf = 0; m_stall = 0;
  endtask

  task automatic model_access(input int port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
    int w;
    w = (addr / 4) % 64;
    exp_en = 1; exp_we = we; exp_addr = (addr / 4) * 4;
    exp_be = we ? be : 4'hF;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      m_pend = port; m_pend_data = ref_mem[w];
    end
  endtask

  // Computes expectations for the current cycle's inputs, then advances.
  task automatic model_step();
    exp_rv0 = (m_pend == 1);
    exp_rv1 = (m_pend == 2);
    if (exp_rv0) m_last0 = m_pend_data;
    if (exp_rv1) m_last1 = m_pend_data;
    exp_rd0 = m_last0;
    exp_rd1 = m_last1;
    if (ireq0 && ireq1) begin
      exp_g0 = (m_ptr == 0);
      exp_g1 = (m_ptr == 1);
      m_conf++;
    end else begin
      exp_g0 = ireq0;
      exp_g1 = ireq1;
    end
    exp_stall0 = ireq0 && !exp_g0;
    if (exp_stall0) m_stall++;
    m_pend = 0; exp_en = 0; exp_we = 0; exp_addr = 0; exp_be = 0;
    if (exp_g0) begin
      model_access(1, iwe0, iaddr0, iwdata0, ibe0); m_ptr = 1;
    end else if (exp_g1) begin
      model_access(2, iwe1, iaddr1, iwdata1, ibe1); m_ptr = 0;
    end
  endtask

  task automatic set0(input logic req, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    ireq0 = req; iwe0 = we; iaddr0 = a; iwdata0 = d; ibe0 = be;
  endtask

  task automatic set1(input logic req, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    ireq1 = req; iwe1 = we; iaddr1 = a; iwdata1 = d; ibe1 = be;
  endtask

  // Next cycle: inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    irst = 1'b1;
    next_cycle(); next_cycle();
    irst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    irst = 1'b1;
    next_cycle(); #4;
    checks++; if (orvalid0 !== 1'b0 || orvalid1 !== 1'b0) begin errors++;
      $display("FAIL reset_rvalid got %b%b want 00", orvalid0, orvalid1); end
    checks++; if (ordata0 !== 32'h0 || ordata1 !== 32'h0) begin errors++;
      $display("FAIL reset_rdata got %h/%h want 0/0", ordata0, ordata1); end
    checks++; if (omem_en !== 1'b0 || omem_we !== 1'b0 || omem_be !== 4'h0 || ogrant0 !== 1'b0 || ostall0 !== 1'b0) begin errors++;
      $display("FAIL reset_idle got en=%b we=%b be=%h g0=%b st=%b want all 0", omem_en, omem_we, omem_be, ogrant0, ostall0); end
    next_cycle();
    irst = 1'b0;
    model_reset();
  endtask

  task automatic test_cpu_read();
    do_reset();
    set0(1, 0, 96, 0, 0);
    model_step(); #4;
    checks++; if (ogrant0 !== exp_g0 || ogrant0 !== 1'b1) begin errors++;
      $display("FAIL cpu_read_grant got %b want 1", ogrant0); end
    checks++; if (omem_en !== 1'b1 || omem_be !== 4'hF || omem_addr !== 32'd96) begin errors++;
      $display("FAIL cpu_read_mem got en=%b be=%h addr=%0d want 1/f/96", omem_en, omem_be, omem_addr); end
    next_cycle();
    set0(0, 0, 0, 0, 0);
    model_step(); #4;
    checks++; if (orvalid0 !== 1'b1 || ordata0 !== exp_rd0 || ordata0 !== 32'hAABBC0DD) begin errors++;
      $display("FAIL cpu_read_data got v=%b d=%h want 1 %h", orvalid0, ordata0, exp_rd0); end
    checks++; if (orvalid1 !== 1'b0) begin errors++;
      $display("FAIL cpu_read_rvalid1 got %b want 0", orvalid1); end
    next_cycle();
    model_step(); #4;
    checks++; if (orvalid0 !== 1'b0 || ordata0 !== exp_rd0) begin errors++;
      $display("FAIL cpu_read_hold got v=%b d=%h want 0 %h", orvalid0, ordata0, exp_rd0); end
    next_cycle();
  endtask

  task automatic test_conflict();
    do_reset();
    set0(1, 1, 100, 25, 4'hF);
    set1(1, 0, 100, 0, 0);
    model_step(); #4;
    checks++; if (ogrant0 !== 1'b1 || ogrant1 !== 1'b0 || ostall0 !== 1'b0) begin errors++;
      $display("FAIL conflict_first got g0=%b g1=%b st=%b want 1 0 0", ogrant0, ogrant1, ostall0); end
    next_cycle();
    set0(0, 0, 0, 0, 0);
    model_step(); #4;
    checks++; if (ogrant1 !== exp_g1 || ogrant1 !== 1'b1) begin errors++;
      $display("FAIL conflict_second got g1=%b want 1", ogrant1); end
    next_cycle();
    set1(0, 0, 0, 0, 0);
    model_step(); #4;
    checks++; if (orvalid1 !== 1'b1 || ordata1 !== 32'd25 || orvalid0 !== 1'b0) begin errors++;
      $display("FAIL conflict_data got v1=%b d1=%0d v0=%b want 1 25 0", orvalid1, ordata1, orvalid0); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        set0(1, 0, 32'($urandom_range(0, 255)), 0, 0);
        set1(1, 0, 32'($urandom_range(0, 255)), 0, 0);
      end else begin
        set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
      end
      model_step(); #4;
      if (i < 6) begin
        checks++; if (ogrant0 !== ((i % 2) == 0) || ogrant1 !== ((i % 2) == 1) || ostall0 !== ((i % 2) == 1)) begin errors++;
          $display("FAIL b2b_grant cyc=%0d got g0=%b g1=%b st=%b want %b %b %b", i, ogrant0, ogrant1, ostall0, (i % 2) == 0, (i % 2) == 1, (i % 2) == 1); end
      end
      if (i > 0) begin
        checks++; if (orvalid0 !== exp_rv0 || orvalid1 !== exp_rv1 || ordata0 !== exp_rd0 || ordata1 !== exp_rd1) begin errors++;
          $display("FAIL b2b_data cyc=%0d got %b%b %h %h want %b%b %h %h", i, orvalid0, orvalid1, ordata0, ordata1, exp_rv0, exp_rv1, exp_rd0, exp_rd1); end
      end
      next_cycle();
    end
  endtask

  task automatic test_byte_enables();
    do_reset();
    set0(1, 1, 99, 32'h77000000, 4'b1000);
    model_step(); #4;
    checks++; if (omem_addr !== 32'd96 || omem_be !== 4'b1000 || omem_we !== 1'b1) begin errors++;
      $display("FAIL sb_mem got addr=%0d be=%b we=%b want 96 1000 1", omem_addr, omem_be, omem_we); end
    next_cycle();
    set0(1, 1, 96, 32'h12345678, 4'b0000);
    model_step(); #4;
    checks++; if (ogrant0 !== 1'b1 || omem_en !== 1'b1 || omem_be !== 4'b0000) begin errors++;
      $display("FAIL be0_noop got g0=%b en=%b be=%b want 1 1 0000", ogrant0, omem_en, omem_be); end
    next_cycle();
    set0(1, 0, 96, 0, 0);
    model_step();
    next_cycle();
    set0(0, 0, 0, 0, 0);
    model_step(); #4;
    checks++; if (orvalid0 !== 1'b1 || ordata0 !== 32'h77BBC0DD || ordata0 !== exp_rd0) begin errors++;
      $display("FAIL sb_readback got v=%b d=%h want 1 77bbc0dd", orvalid0, ordata0); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    set0(1, 0, 96, 0, 0);
    #2 irst = 1'b1;
    next_cycle();
    set0(0, 0, 0, 0, 0);
    #2 irst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (orvalid0 !== 1'b0 || ordata0 !== 32'h0) begin errors++;
        $display("FAIL rst_mid_read cyc=%0d got v=%b d=%h want 0 0", i, orvalid0, ordata0); end
      next_cycle();
    end
    set0(1, 0, 4, 0, 0); set1(1, 0, 8, 0, 0);
    model_step(); #4;
    checks++; if (ogrant0 !== 1'b1 || ogrant1 !== 1'b0) begin errors++;
      $display("FAIL rst_ptr got g0=%b g1=%b want 1 0", ogrant0, ogrant1); end
    next_cycle();
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    model_step();
    next_cycle();
  endtask

  task automatic test_random();
    logic act0, act1;
    do_reset();
    act0 = 0; act1 = 0;
    for (int i = 0; i < 300; i++) begin
      // Pending requests keep their fields until granted.
      if (!act0 && ($urandom_range(0, 2) != 0)) begin
        act0 = 1;
        set0(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom, 4'($urandom));
      end else if (!act0) ireq0 = 0;
      if (!act1 && ($urandom_range(0, 2) != 0)) begin
        act1 = 1;
        set1(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom, 4'($urandom));
      end else if (!act1) ireq1 = 0;
      model_step(); #4;
      checks++; if (ogrant0 !== exp_g0 || ogrant1 !== exp_g1 || ostall0 !== exp_stall0) begin errors++;
        $display("FAIL rand_grant cyc=%0d got %b%b%b want %b%b%b", i, ogrant0, ogrant1, ostall0, exp_g0, exp_g1, exp_stall0); end
      checks++; if (omem_en !== exp_en || (exp_en && (omem_we !== exp_we || omem_addr !== exp_addr || omem_be !== exp_be))) begin errors++;
        $display("FAIL rand_mem cyc=%0d got en=%b we=%b a=%h be=%h want %b %b %h %h", i, omem_en, omem_we, omem_addr, omem_be, exp_en, exp_we, exp_addr, exp_be); end
      checks++; if (orvalid0 !== exp_rv0 || orvalid1 !== exp_rv1 || ordata0 !== exp_rd0 || ordata1 !== exp_rd1) begin errors++;
        $display("FAIL rand_rdata cyc=%0d got %b%b %h %h want %b%b %h %h", i, orvalid0, orvalid1, ordata0, ordata1, exp_rv0, exp_rv1, exp_rd0, exp_rd1); end
      if (exp_g0) act0 = 0;
      if (exp_g1) act1 = 0;
      next_cycle();
    end
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    next_cycle();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set0(1, 0, 32'($urandom_range(0, 255)), 0, 0);
      set1(1, 0, 32'($urandom_range(0, 255)), 0, 0);
      model_step();
      next_cycle();
    end
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    #4;
    checks++; if (ostat_conflicts !== 32'(m_conf) || ostat_conflicts !== 32'd5) begin errors++;
      $display("FAIL stat_conflicts got %0d want 5", ostat_conflicts); end
    checks++; if (ostat_stall0 !== 32'(m_stall)) begin errors++;
      $display("FAIL stat_stall0 got %0d want %0d", ostat_stall0, m_stall); end
    next_cycle();
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = 32'h01010101 * i + 32'h5A000000;
      ref_mem[i] = 32'h01010101 * i + 32'h5A000000;
    end
    tb_mem[24]  = 32'hAABBC0DD;
    ref_mem[24] = 32'hAABBC0DD;
    imem_rdata  = '0;
    model_reset();
    test_reset();
    test_cpu_read();
    test_conflict();
    test_back_to_back();
    test_byte_enables();
    test_reset_mid_read();
    test_random();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates a single-port, synchronous-read data memory between two requesters: port 0 = CPU memory stage (lw/sw/lb/lh/sb/sh traffic), port 1 = debug/loader DMA that preloads and inspects data memory.
- Round-robin arbitration, one access per cycle, 1-cycle read latency, per-byte write enables for sub-word stores.
- CPU stalls while it is not granted.
- Sits between the core's MEM stage/loader and the dmem instance inside top.

Parameters:
- DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- ADDR_WIDTH, 32, byte address width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived, not overridable).

Ports:
- iclk  in  1  clock
- irst  in  1  asynchronous active-high reset
- ireq0  in  1  CPU access request
- iwe0  in  1  CPU write (1) / read (0)
- iaddr0  in  ADDR_WIDTH  CPU byte address
- iwdata0  in  DATA_WIDTH  CPU write data, lane-aligned
- ibe0  in  BE_WIDTH  CPU byte enables
- ogrant0  out  1  CPU access accepted this cycle
- ostall0  out  1  ireq0 & ~ogrant0 (combinational, drives pipeline stall)
- ordata0  out  DATA_WIDTH  CPU read data
- orvalid0  out  1  ordata0 valid
- ireq1, iwe1, iaddr1, iwdata1, ibe1, ogrant1, ordata1, orvalid1: same as port 0, for DMA
- omem_en  out  1  memory access enable
- omem_we  out  1  memory write
- omem_addr  out  ADDR_WIDTH  memory byte address
- omem_wdata  out  DATA_WIDTH  memory write data
- omem_be  out  BE_WIDTH  memory byte enables
- imem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read

Behaviour:
- Reset (async, irst=1): priority pointer = port 0. orvalid0/1 = 0, ordata0/1 = 0, rd_owner register = none. Combinational outputs follow from the cleared state with no requests pending.
- Grant is combinational in the request cycle:
  - Exactly one requester: it is granted.
  - Both requesting: grant the port selected by the priority pointer.
  - After any grant, the pointer moves to the other port (round robin), so each port waits at most 1 cycle under contention.
- Granted port drives omem_*:
  - omem_en = 1.
  - omem_be = ibe on writes; all ones on reads.
  - omem_addr is word-aligned (low log2(BE_WIDTH) bits cleared).
- No grant: omem_en=0, omem_we=0, omem_be=0.
- Reads: a granted read in cycle N records the owner. In N+1, ordataX = imem_rdata and orvalidX = 1 for one cycle. Back-to-back reads are pipelined, one per cycle. Writes never assert orvalid.
- ordataX holds its last value when orvalidX = 0.
- Byte-enable rules:
  - ibe = 0 on a write is a legal no-op access: granted, but omem_be = 0.
  - Read lane extraction and sign extension belong to the core, not this block.
- A requester must hold ireq and its request fields stable until granted.
- Reset asserted mid-read: the pending rvalid is dropped, and no orvalid appears after reset release.
- Simultaneous write by port 0 and read by port 1 to the same address: the pointer decides order; the read returns pre- or post-write data according to that order.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds output ostat_conflicts (32 bits): increments each cycle both ireq0 and ireq1 are high; saturates at all ones.
  - Adds output ostat_stall0 (32 bits): counts cycles with ostall0 high; saturates at all ones.
  - Both counters cleared by irst.
- Undefined: ports and counters are absent; no other behaviour change.

Decomposition:
- Package dmem_arb_pkg:
  - typedef port_id_t (1 bit), constants PORT_CPU=0 and PORT_DMA=1.
  - typedef rd_owner_t {NONE, CPU, DMA}.
- Sub-module rr_arbiter2: 2-way round-robin grant with pointer register; instantiated once.
- Datapath muxing and read-return logic stay in dmem_arbiter.

Test Plan:
- Reset, then CPU-only read of addr 96 (memory word 0xAABBC0DD) -> ogrant0=1 in the request cycle; next cycle orvalid0=1, ordata0=0xAABBC0DD; orvalid1=0.
- Both ports request in the same cycle after reset (CPU write 25 to addr 100, DMA read addr 100) -> CPU granted first, ostall0=0; DMA granted the next cycle; ordata1=25.
- Both ports hold requests for 6 cycles -> grants alternate 0,1,0,1,0,1; ostall0 is high on the DMA cycles only.
- CPU sb to addr 99 with ibe0=4'b1000, iwdata0=0x77000000 -> omem_addr=96, omem_be=4'b1000; a later read of 96 returns 0x77BBC0DD.
- Read issued, then irst pulsed before the data cycle -> no orvalid0 in any cycle after reset release; pointer back at port 0.
- With DMEM_ARB_STATS_EN: 5 contention cycles -> ostat_conflicts=5 and ostat_stall0 equals the number of cycles CPU was not granted.
